// File: rtl/p2s_buf.sv
// p2s_buf: parallel-to-serial converter with a one-word hold buffer.
// Words stream back-to-back; bit order and beat width are parameters.
module p2s_buf #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] p_data,
  input  logic         p_valid,
  output logic         p_ready,
  output logic [W-1:0] s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         s_last
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad
    $error("p2s_buf: N must be a multiple of W, 1 <= W <= N");
  end

  logic [N-1:0]  sr;
  logic [N-1:0]  hd;
  logic          sv;
  logic          hv;
  logic [CW-1:0] cnt;

  logic p_acc;
  logic s_acc;
  logic free;

  assign p_ready = ~hv;
  assign s_valid = sv;
  assign s_last  = sv & (cnt == LAST);
  assign p_acc   = p_valid & p_ready;
  assign s_acc   = sv & s_ready;
  assign free    = ~sv | (s_acc & s_last);

  if (MSB_FIRST) begin : g_msb
    assign s_data = sr[N-1 -: W];
  end else begin : g_lsb
    assign s_data = sr[W-1:0];
  end

  // Shifter reload from hold or input, hold capture, and beat shifting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= '0;
      hd  <= '0;
      sv  <= 1'b0;
      hv  <= 1'b0;
      cnt <= '0;
    end else if (free) begin
      cnt <= '0;
      if (hv) begin
        sr <= hd;
        sv <= 1'b1;
        hv <= 1'b0;
      end else if (p_acc) begin
        sr <= p_data;
        sv <= 1'b1;
      end else begin
        sv <= 1'b0;
      end
    end else begin
      if (p_acc) begin
        hd <= p_data;
        hv <= 1'b1;
      end
      if (s_acc) begin
        sr  <= MSB_FIRST ? (sr << W) : (sr >> W);
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_p2s_buf.sv
// tb_p2s_buf: three p2s_buf configurations on shared stimulus,
// each checked every cycle against a word-queue reference model.
module tb_p2s_buf;

  localparam int WW [3] = '{1, 2, 8};

  logic       clk;
  logic       rstn;
  logic [7:0] p_data;
  logic       p_valid;
  logic       s_ready;

  logic       pr0, pr1, pr2;
  logic       sv0, sv1, sv2;
  logic       sl0, sl1, sl2;
  logic [0:0] sd0;
  logic [1:0] sd1;
  logic [7:0] sd2;

  logic       pr [3];
  logic       sv [3];
  logic       sl [3];
  logic [7:0] sd [3];

  assign pr[0] = pr0;
  assign pr[1] = pr1;
  assign pr[2] = pr2;
  assign sv[0] = sv0;
  assign sv[1] = sv1;
  assign sv[2] = sv2;
  assign sl[0] = sl0;
  assign sl[1] = sl1;
  assign sl[2] = sl2;
  assign sd[0] = {7'd0, sd0};
  assign sd[1] = {6'd0, sd1};
  assign sd[2] = sd2;

  p2s_buf #(.N(8), .W(1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rstn(rstn),
    .p_data(p_data), .p_valid(p_valid), .p_ready(pr0),
    .s_data(sd0), .s_valid(sv0), .s_ready(s_ready), .s_last(sl0)
  );

  p2s_buf #(.N(8), .W(2), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rstn(rstn),
    .p_data(p_data), .p_valid(p_valid), .p_ready(pr1),
    .s_data(sd1), .s_valid(sv1), .s_ready(s_ready), .s_last(sl1)
  );

  p2s_buf #(.N(8), .W(8), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rstn(rstn),
    .p_data(p_data), .p_valid(p_valid), .p_ready(pr2),
    .s_data(sd2), .s_valid(sv2), .s_ready(s_ready), .s_last(sl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // reference model: up to two words in flight, plus beat index
  logic [7:0] wbuf [3][4];
  int whead [3] = '{0, 0, 0};
  int wcnt  [3] = '{0, 0, 0};
  int beat  [3] = '{0, 0, 0};

  function automatic int beat_val(input logic [7:0] wd,
                                  input int i, input int j);
    int w;
    int sh;
    w  = WW[i];
    sh = (i == 1) ? w * j : 8 - w * (j + 1);
    return int'((wd >> sh) & 8'((1 << w) - 1));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn) begin
        wcnt[i]  = 0;
        whead[i] = 0;
        beat[i]  = 0;
      end else begin
        bit pa;
        pa = p_valid && (wcnt[i] < 2);
        if (wcnt[i] > 0 && s_ready) begin
          if (beat[i] == 8 / WW[i] - 1) begin
            beat[i]  = 0;
            whead[i] = (whead[i] + 1) % 4;
            wcnt[i]--;
          end else begin
            beat[i]++;
          end
        end
        if (pa) begin
          wbuf[i][(whead[i] + wcnt[i]) % 4] = p_data;
          wcnt[i]++;
        end
      end
    end
  end

  // captured accepted beats, for whole-word checks
  int cap   [3];
  int nbeat [3];
  int nl    [3];

  task automatic clr_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i]   = 0;
      nbeat[i] = 0;
      nl[i]    = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        bit ev;
        bit el;
        ev = (wcnt[i] > 0);
        el = ev && (beat[i] == 8 / WW[i] - 1);
        chk($sformatf("u%0d.s_valid", i), int'(sv[i]), int'(ev));
        chk($sformatf("u%0d.s_last", i), int'(sl[i]), int'(el));
        chk($sformatf("u%0d.p_ready", i), int'(pr[i]),
            int'(wcnt[i] < 2));
        if (ev)
          chk($sformatf("u%0d.s_data", i), int'(sd[i]),
              beat_val(wbuf[i][whead[i]], i, beat[i]));
        if (sv[i] && s_ready) begin
          cap[i] = (cap[i] << WW[i]) | int'(sd[i]);
          nbeat[i]++;
          if (sl[i]) nl[i]++;
        end
      end
    end
  end

  task automatic step(input bit pv, input logic [7:0] pd,
                      input bit rdy);
    @(posedge clk);
    #1;
    p_valid = pv;
    p_data  = pd;
    s_ready = rdy;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.u%0d.s_valid", tag, i), int'(sv[i]), 0);
      chk($sformatf("%s.u%0d.s_last", tag, i), int'(sl[i]), 0);
      chk($sformatf("%s.u%0d.s_data", tag, i), int'(sd[i]), 0);
      chk($sformatf("%s.u%0d.p_ready", tag, i), int'(pr[i]), 1);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    p_valid = 1'b0;
    p_data  = 8'h00;
    s_ready = 1'b1;
    clr_cap();
    #1;
    chk_reset("rst");
    @(posedge clk);
    #2 rstn = 1'b1;
    drain(2);

    // single word, MSB-first serial
    clr_cap();
    step(1'b1, 8'd62, 1'b1);
    drain(12);
    chk("t1.u0.seq", cap[0], 62);
    chk("t1.u0.beats", nbeat[0], 8);
    chk("t1.u0.last", nl[0], 1);

    // 2-bit LSB-first beats 00,01,11,10
    clr_cap();
    step(1'b1, 8'hB4, 1'b1);
    drain(12);
    chk("t2.u1.seq", cap[1], 'h1E);
    chk("t2.u1.beats", nbeat[1], 4);
    chk("t2.u1.last", nl[1], 1);

    // back-to-back words, second goes to hold
    clr_cap();
    step(1'b1, 8'd62, 1'b1);
    step(1'b1, 8'd52, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t3.u0.hold_pr", int'(pr[0]), 0);
    drain(20);
    chk("t3.u0.seq", cap[0], 62 * 256 + 52);
    chk("t3.u0.beats", nbeat[0], 16);
    chk("t3.u0.last", nl[0], 2);

    // backpressure on beat 3
    clr_cap();
    step(1'b1, 8'd62, 1'b1);
    drain(3);
    repeat (3) begin
      step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("t4.hold.data", int'(sd[0]), 1);
      chk("t4.hold.valid", int'(sv[0]), 1);
    end
    drain(12);
    chk("t4.u0.seq", cap[0], 62);
    chk("t4.u0.beats", nbeat[0], 8);

    // reset mid-word with a word held
    step(1'b1, 8'd62, 1'b1);
    step(1'b1, 8'd52, 1'b1);
    drain(4);
    #2 rstn = 1'b0;
    #1;
    chk_reset("t5");
    @(posedge clk);
    #2 rstn = 1'b1;
    clr_cap();
    step(1'b1, 8'hA5, 1'b1);
    drain(12);
    chk("t5.u0.seq", cap[0], 'hA5);
    chk("t5.u0.beats", nbeat[0], 8);

    // full-width beats streamed
    clr_cap();
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    drain(24);
    chk("t6.u2.seq", cap[2], 'h112233);
    chk("t6.u2.beats", nbeat[2], 3);
    chk("t6.u2.last", nl[2], 3);

    // random traffic with random backpressure
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 99) < 60,
           8'($urandom),
           $urandom_range(0, 99) < 70);
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/p2s_buf.md
Name: p2s_buf

Overview:
- Parametrised parallel-to-serial converter, successor to the basic p2s.
- Accepts N-bit words on a valid/ready parallel port and emits them as N/W beats of W bits on a valid/ready serial port.
- Bit order is selectable (MSB- or LSB-first), and s_last marks the final beat of each word.
- A one-word holding buffer accepts the next word while the current one shifts, so words stream back-to-back with no gap beats.

Parameters:
- N, 8, parallel word width in bits.
- W, 1, serial beat width in bits; N % W == 0 and 1 <= W <= N, else $error at elaboration.
- MSB_FIRST, 1, 1 = most-significant beat first, 0 = least-significant beat first.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- p_data  input  N  parallel word.
- p_valid  input  1  p_data valid.
- p_ready  output  1  block can accept a word.
- s_data  output  W  current serial beat.
- s_valid  output  1  s_data valid.
- s_ready  input  1  downstream accepts beat.
- s_last  output  1  current beat is the final beat of its word.

Behaviour:
- Derived constants: BEATS = N/W; CW = max(1, $clog2(BEATS)).
- State registers:
  - shift register sr[N-1:0] with flag sv (drives s_valid);
  - beat counter cnt[CW-1:0];
  - holding register hd[N-1:0] with flag hv.
- Reset (rstn low, asynchronous): sv=0, hv=0, cnt=0, sr=0, hd=0. Outputs: s_valid=0, s_last=0, s_data=0, p_ready=1. Any word in flight is dropped.
- p_ready = ~hv, driven purely from a register. Parallel handshake p_acc = p_valid & p_ready.
- Serial handshake s_acc = s_valid & s_ready. s_last = sv & (cnt == BEATS-1).
- s_data:
  - MSB_FIRST=1: sr[N-1 -: W], shift left by W on each non-final s_acc.
  - MSB_FIRST=0: sr[W-1:0], shift right by W on each non-final s_acc.
  - Vacated bits fill with 0.
- Shifter free condition: free = ~sv | (s_acc & s_last).
- Rising-edge priority:
  - free & hv: load sr<=hd, sv<=1, cnt<=0, hv<=0. A p_acc on the same edge is impossible because p_ready=0.
  - free & ~hv & p_acc: load sr<=p_data, sv<=1, cnt<=0.
  - free & ~hv & ~p_acc: sv<=0 if finishing, cnt<=0.
  - ~free & p_acc: hd<=p_data, hv<=1.
  - s_acc & ~s_last: shift sr, cnt<=cnt+1.
- Latency: a word accepted into an idle block drives its first beat on s_data after the same edge (1 cycle register latency).
- Throughput: 1 beat/cycle sustained with s_ready=1; word k+1 first beat directly follows word k last beat.
- Backpressure: while s_ready=0, s_data, s_valid and s_last hold stable. The hold buffer can still absorb one word; after that p_ready=0.
- BEATS=1 (W=N): s_last = s_valid always; the counter never increments; every s_acc is a word completion.
- cnt wraps only via reload to 0, never by overflow.
- p_data is ignored when p_ready=0 or p_valid=0.

Test Plan:
- N=8,W=1,MSB_FIRST=1, s_ready=1, single p_data=8'd62 pulse:
  - s_data = 0,0,1,1,1,1,1,0 on 8 consecutive cycles;
  - s_last only on 8th beat;
  - s_valid low afterwards; p_ready stays 1.
- N=8,W=2,MSB_FIRST=0, p_data=8'hB4: beats 2'b00,2'b01,2'b11,2'b10, s_last on beat 4.
- Back-to-back, W=1 MSB-first, p_data=62 then 52 on consecutive cycles, s_ready=1:
  - 52 lands in hold and p_ready goes low;
  - 16 contiguous s_valid beats: 00111110 then 00110100;
  - p_ready returns high on the cycle after word 2 loads.
- Backpressure, word 62 with s_ready dropped for 3 cycles after beat 3:
  - s_data=1 and s_valid=1 held for 3 cycles;
  - sequence resumes unchanged; total 8 beats, no duplicates or losses.
- Reset mid-word, rstn low after beat 4 of 62, with a second word held:
  - s_valid, s_last and s_data go 0 immediately and p_ready goes 1;
  - after release, new word 8'hA5 serialises 1,0,1,0,0,1,0,1 from beat 0.
- N=8,W=8: words 8'h11, 8'h22, 8'h33 streamed:
  - one beat each, in order, s_last=1 on every beat;
  - with s_ready=1, p_ready stays 1 throughout.
